// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline control logic.
package otter_pipe_pkg;

  typedef enum logic [6:0] {
    OpLui    = 7'b0110111,
    OpAuipc  = 7'b0010111,
    OpJal    = 7'b1101111,
    OpJalr   = 7'b1100111,
    OpBranch = 7'b1100011,
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011,
    OpImm    = 7'b0010011,
    OpReg    = 7'b0110011,
    OpSys    = 7'b1110011
  } opcode_t;

  // Widest register address a scoreboard entry can hold; narrower ADDR_W is zero-extended.
  localparam int unsigned RF_ADDR_MAX_W = 8;

  localparam int unsigned FWD_REGFILE = 0;
  localparam int unsigned STG_EX      = 1;
  localparam int unsigned STG_MEM     = 2;

  typedef struct packed {
    logic                     valid;
    logic [RF_ADDR_MAX_W-1:0] rd;
    logic                     reg_write;
    logic                     is_load;
  } hazard_entry_t;

  // An entry whose result someone downstream may need (x0 writes are discarded).
  function automatic logic is_producer(input hazard_entry_t e);
    return e.valid & e.reg_write & (e.rd != '0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) begin
      return v + 32'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/otter_fwd_match.sv
// Youngest-first producer search for one source operand.
// Entry k (0-based) is scoreboard stage k+1; once the consumer enters EX that
// producer sits one stage further on, hence the select value k+2.
module otter_fwd_match
  import otter_pipe_pkg::*;
#(
  parameter int unsigned NumSearch = 2,
  parameter int unsigned FwdW      = 2
) (
  input  logic                           src_used_i,
  input  logic [RF_ADDR_MAX_W-1:0]       src_addr_i,
  input  hazard_entry_t [NumSearch-1:0]  entries_i,
  output logic [FwdW-1:0]                sel_o
);

  logic unused_is_load;

  // Walk oldest to youngest so the youngest match is written last and wins.
  always_comb begin
    sel_o = FwdW'(FWD_REGFILE);
    for (int k = NumSearch - 1; k >= 0; k--) begin
      if (src_used_i && is_producer(entries_i[k]) && (entries_i[k].rd == src_addr_i)) begin
        sel_o = FwdW'(k + 2);
      end
    end
  end

  // Load flags are irrelevant to forwarding.
  always_comb begin
    unused_is_load = 1'b0;
    for (int k = 0; k < NumSearch; k++) begin
      unused_is_load = unused_is_load ^ entries_i[k].is_load;
    end
  end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// Hazard and forwarding controller for the pipelined OTTER core.
// Tracks in-flight instructions behind decode and produces stall, flush,
// bubble and registered forwarding selects.
// Optional macro HAZARD_PERF_EN adds saturating 32-bit performance counters.
module otter_hazard_ctrl
  import otter_pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  de_valid,
  input  logic [ADDR_W-1:0]     de_rs1_addr,
  input  logic [ADDR_W-1:0]     de_rs2_addr,
  input  logic                  de_rs1_used,
  input  logic                  de_rs2_used,
  input  logic [ADDR_W-1:0]     de_rd_addr,
  input  logic                  de_reg_write,
  input  logic                  de_mem_read,
  input  logic                  br_taken,
  input  logic                  mem_ready,
  output logic                  stall_if,
  output logic                  stall_de,
  output logic                  flush_de,
  output logic                  bubble_ex,
  output logic [FWD_W-1:0]      fwd_rs1_sel,
  output logic [FWD_W-1:0]      fwd_rs2_sel,
  output logic [NUM_STAGES-1:0] pipe_valid
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flushes,
  output logic [31:0]           perf_mem_wait
`endif
);

  hazard_entry_t [NUM_STAGES-1:0] entry_q, entry_d;
  hazard_entry_t                  de_entry;
  logic [FWD_W-1:0]               fwd_rs1_q, fwd_rs1_d, fwd_rs2_q, fwd_rs2_d;
  logic [FWD_W-1:0]               match_rs1, match_rs2;
  logic [RF_ADDR_MAX_W-1:0]       rs1_ext, rs2_ext;
  logic                           mem_wait, flush, load_use, rs1_hit, rs2_hit;
  logic                           unused_wb_fields;

  assign rs1_ext = RF_ADDR_MAX_W'(de_rs1_addr);
  assign rs2_ext = RF_ADDR_MAX_W'(de_rs2_addr);

  // The WB entry only contributes its valid bit; the regfile covers its data.
  assign unused_wb_fields = ^{entry_q[NUM_STAGES-1].rd, entry_q[NUM_STAGES-1].reg_write,
                              entry_q[NUM_STAGES-1].is_load};

  // Hazard detection in priority order: mem_wait > flush > load_use.
  always_comb begin
    mem_wait = entry_q[STG_MEM-1].valid & entry_q[STG_MEM-1].is_load & ~mem_ready;
    flush    = br_taken & entry_q[STG_EX-1].valid & ~mem_wait;
    rs1_hit  = de_rs1_used & (rs1_ext == entry_q[STG_EX-1].rd);
    rs2_hit  = de_rs2_used & (rs2_ext == entry_q[STG_EX-1].rd);
    load_use = de_valid & is_producer(entry_q[STG_EX-1]) & entry_q[STG_EX-1].is_load &
               (rs1_hit | rs2_hit) & ~mem_wait & ~flush;
  end

  // Pipeline control outputs.
  always_comb begin
    stall_if    = mem_wait | load_use;
    stall_de    = mem_wait | load_use;
    flush_de    = flush;
    bubble_ex   = flush | load_use;
    fwd_rs1_sel = fwd_rs1_q;
    fwd_rs2_sel = fwd_rs2_q;
    for (int k = 0; k < NUM_STAGES; k++) begin
      pipe_valid[k] = entry_q[k].valid;
    end
  end

  otter_fwd_match #(
    .NumSearch (NUM_STAGES - 1),
    .FwdW      (FWD_W)
  ) u_fwd_rs1 (
    .src_used_i (de_valid & de_rs1_used),
    .src_addr_i (rs1_ext),
    .entries_i  (entry_q[NUM_STAGES-2:0]),
    .sel_o      (match_rs1)
  );

  otter_fwd_match #(
    .NumSearch (NUM_STAGES - 1),
    .FwdW      (FWD_W)
  ) u_fwd_rs2 (
    .src_used_i (de_valid & de_rs2_used),
    .src_addr_i (rs2_ext),
    .entries_i  (entry_q[NUM_STAGES-2:0]),
    .sel_o      (match_rs2)
  );

  // Scoreboard and forwarding-select next state.
  always_comb begin
    de_entry.valid     = de_valid;
    de_entry.rd        = RF_ADDR_MAX_W'(de_rd_addr);
    de_entry.reg_write = de_valid & de_reg_write;
    de_entry.is_load   = de_valid & de_mem_read;

    entry_d   = entry_q;
    fwd_rs1_d = fwd_rs1_q;
    fwd_rs2_d = fwd_rs2_q;
    if (!mem_wait) begin
      for (int k = NUM_STAGES - 1; k > 0; k--) begin
        entry_d[k] = entry_q[k-1];
      end
      if (flush || load_use) begin
        // EX receives a NOP, which needs no operands.
        entry_d[0] = '0;
        fwd_rs1_d  = FWD_W'(FWD_REGFILE);
        fwd_rs2_d  = FWD_W'(FWD_REGFILE);
      end else begin
        entry_d[0] = de_entry;
        fwd_rs1_d  = match_rs1;
        fwd_rs2_d  = match_rs2;
      end
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      entry_q   <= '0;
      fwd_rs1_q <= '0;
      fwd_rs2_q <= '0;
    end else begin
      entry_q   <= entry_d;
      fwd_rs1_q <= fwd_rs1_d;
      fwd_rs2_q <= fwd_rs2_d;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, wait_cnt_q, wait_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d       = sat_inc(stall_cnt_q, stall_if);
    flush_cnt_d       = sat_inc(flush_cnt_q, flush);
    wait_cnt_d        = sat_inc(wait_cnt_q, mem_wait);
    perf_stall_cycles = stall_cnt_q;
    perf_flushes      = flush_cnt_q;
    perf_mem_wait     = wait_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Bench for otter_hazard_ctrl: a 3-stage and a 5-stage instance share stimulus.
// An instruction-level pipeline model is checked every cycle; directed
// scenarios add hand-computed expectations.
module tb_otter_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       de_valid, u1, u2, rw, ml, br, mr;
  logic [4:0] rs1, rs2, rd;

  logic       s3_if, s3_de, f3, b3, s5_if, s5_de, f5, b5;
  logic [1:0] r1_3, r2_3;
  logic [2:0] r1_5, r2_5, pv3;
  logic [4:0] pv5;
`ifdef HAZARD_PERF_EN
  logic [31:0] ps3, pf3, pw3, ps5, pf5, pw5;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  otter_hazard_ctrl #(.NUM_STAGES(3), .ADDR_W(5)) u_dut3 (
    .CLK(clk), .RESET_N(rst_n), .de_valid(de_valid),
    .de_rs1_addr(rs1), .de_rs2_addr(rs2), .de_rs1_used(u1), .de_rs2_used(u2),
    .de_rd_addr(rd), .de_reg_write(rw), .de_mem_read(ml), .br_taken(br), .mem_ready(mr),
    .stall_if(s3_if), .stall_de(s3_de), .flush_de(f3), .bubble_ex(b3),
    .fwd_rs1_sel(r1_3), .fwd_rs2_sel(r2_3), .pipe_valid(pv3)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(ps3), .perf_flushes(pf3), .perf_mem_wait(pw3)
`endif
  );

  otter_hazard_ctrl #(.NUM_STAGES(5), .ADDR_W(5)) u_dut5 (
    .CLK(clk), .RESET_N(rst_n), .de_valid(de_valid),
    .de_rs1_addr(rs1), .de_rs2_addr(rs2), .de_rs1_used(u1), .de_rs2_used(u2),
    .de_rd_addr(rd), .de_reg_write(rw), .de_mem_read(ml), .br_taken(br), .mem_ready(mr),
    .stall_if(s5_if), .stall_de(s5_de), .flush_de(f5), .bubble_ex(b5),
    .fwd_rs1_sel(r1_5), .fwd_rs2_sel(r2_5), .pipe_valid(pv5)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(ps5), .perf_flushes(pf5), .perf_mem_wait(pw5)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instruction-level model ----------------
  typedef struct {
    bit v;
    bit wr;
    bit ld;
    int rd;
  } ins_t;

  ins_t        mp   [2][8];    // [instance][stage-1], index 0 = EX
  int          msel [2][2];
  int          nst  [2] = '{3, 5};
  int unsigned mstall [2], mflush [2], mwait [2];

  function automatic int youngest(input int i, input int src, input bit used);
    if (!used || !de_valid) return 0;
    for (int k = 0; k < nst[i] - 1; k++) begin
      if (mp[i][k].v && mp[i][k].wr && mp[i][k].rd != 0 && mp[i][k].rd == src) return k + 2;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) mp[i][k] = '{default: 0};
      msel[i][0] = 0;
      msel[i][1] = 0;
      mstall[i] = 0;
      mflush[i] = 0;
      mwait[i] = 0;
    end
  endtask

  // Compare every cycle on the falling edge, then advance the model to the
  // state the next rising edge will produce.
  always @(negedge clk) begin : compare
    bit          w, fl, lu;
    int          y1, y2;
    logic [7:0]  epv, gpv;
    logic [31:0] gs1, gs2;
    logic        gst, gsd, gfl, gbb;
    string       tag;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        tag = (i == 0) ? "n3" : "n5";
        w  = mp[i][1].v && mp[i][1].ld && !mr;
        fl = br && mp[i][0].v && !w;
        lu = de_valid && mp[i][0].v && mp[i][0].ld && mp[i][0].wr && mp[i][0].rd != 0 &&
             ((u1 && int'(rs1) == mp[i][0].rd) || (u2 && int'(rs2) == mp[i][0].rd)) && !w && !fl;
        epv = '0;
        for (int k = 0; k < nst[i]; k++) epv[k] = mp[i][k].v;
        if (i == 0) begin
          gst = s3_if; gsd = s3_de; gfl = f3; gbb = b3;
          gs1 = 32'(r1_3); gs2 = 32'(r2_3); gpv = 8'(pv3);
        end else begin
          gst = s5_if; gsd = s5_de; gfl = f5; gbb = b5;
          gs1 = 32'(r1_5); gs2 = 32'(r2_5); gpv = 8'(pv5);
        end
        chk({tag, " stall_if"}, 32'(gst), 32'(w || lu));
        chk({tag, " stall_de"}, 32'(gsd), 32'(w || lu));
        chk({tag, " flush_de"}, 32'(gfl), 32'(fl));
        chk({tag, " bubble_ex"}, 32'(gbb), 32'(fl || lu));
        chk({tag, " fwd_rs1_sel"}, gs1, msel[i][0]);
        chk({tag, " fwd_rs2_sel"}, gs2, msel[i][1]);
        chk({tag, " pipe_valid"}, 32'(gpv), 32'(epv));
`ifdef HAZARD_PERF_EN
        chk({tag, " perf_stall"}, (i == 0) ? ps3 : ps5, mstall[i]);
        chk({tag, " perf_flush"}, (i == 0) ? pf3 : pf5, mflush[i]);
        chk({tag, " perf_wait"}, (i == 0) ? pw3 : pw5, mwait[i]);
`endif
        if (w || lu) mstall[i]++;
        if (fl) mflush[i]++;
        if (w) mwait[i]++;
        if (!w) begin
          y1 = youngest(i, int'(rs1), u1);
          y2 = youngest(i, int'(rs2), u2);
          for (int k = nst[i] - 1; k > 0; k--) mp[i][k] = mp[i][k-1];
          if (fl || lu) begin
            mp[i][0] = '{default: 0};
            msel[i][0] = 0;
            msel[i][1] = 0;
          end else begin
            mp[i][0] = '{v: de_valid, wr: de_valid && rw, ld: de_valid && ml, rd: int'(rd)};
            msel[i][0] = y1;
            msel[i][1] = y2;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic v, input int a1, input logic uu1, input int a2,
                       input logic uu2, input int d, input logic w, input logic ld);
    de_valid = v;
    rs1 = 5'(a1); u1 = uu1;
    rs2 = 5'(a2); u2 = uu2;
    rd = 5'(d); rw = w; ml = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    br = 0;
    mr = 1;
    repeat (6) tick();
  endtask

  initial begin
    rst_n = 0;
    br = 0;
    mr = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset pipe_valid", 32'(pv3), 0);
    chk("reset stall_if", 32'(s3_if), 0);
    chk("reset fwd_rs1", 32'(r1_3), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // add x5,x1,x2 ; sub x6,x5,x1
    drive(1, 1, 1, 2, 1, 5, 1, 0);
    tick();
    drive(1, 5, 1, 1, 1, 6, 1, 0);
    #1 chk("alu no stall", 32'(s3_if), 0);
    tick();
    chk("alu fwd_rs1", 32'(r1_3), 2);
    chk("alu fwd_rs2", 32'(r2_3), 0);
    drain();

    // lw x7 ; add x8,x7,x7
    drive(1, 1, 1, 0, 0, 7, 1, 1);
    tick();
    drive(1, 7, 1, 7, 1, 8, 1, 0);
    #1;
    chk("lu stall_if", 32'(s3_if), 1);
    chk("lu stall_de", 32'(s3_de), 1);
    chk("lu bubble_ex", 32'(b3), 1);
    tick();
    chk("lu released", 32'(s3_if), 0);
    chk("lu pipe_valid", 32'(pv3), 32'h2);
    tick();
    chk("lu fwd_rs1", 32'(r1_3), 3);
    chk("lu fwd_rs2", 32'(r2_3), 3);
    chk("lu fwd_rs1 n5", 32'(r1_5), 3);
    drain();

    // addi x4 ; lw x9,(x4) ; add x11,x4,x2 ; sub x12,x11,x9 with a 4-cycle memory wait
    drive(1, 1, 1, 0, 0, 4, 1, 0);
    tick();
    drive(1, 4, 1, 0, 0, 9, 1, 1);
    tick();
    chk("lw fwd_rs1", 32'(r1_3), 2);
    drive(1, 4, 1, 2, 1, 11, 1, 0);
    tick();
    drive(1, 11, 1, 9, 1, 12, 1, 0);
    mr = 0;
    #1;
    for (int j = 0; j < 4; j++) begin
      chk("wait stall_if", 32'(s3_if), 1);
      chk("wait pipe_valid", 32'(pv3), 32'h7);
      chk("wait fwd_rs1", 32'(r1_3), 3);
      chk("wait fwd_rs2", 32'(r2_3), 0);
      tick();
    end
    mr = 1;
    #1 chk("wait released", 32'(s3_if), 0);
    tick();
    chk("resume fwd_rs1", 32'(r1_3), 2);
    chk("resume fwd_rs2", 32'(r2_3), 3);
    drain();

    // lw x13 ; taken branch with a load-use consumer in DE
    drive(1, 1, 1, 0, 0, 13, 1, 1);
    tick();
    drive(1, 13, 1, 2, 1, 14, 1, 0);
    br = 1;
    #1;
    chk("br flush_de", 32'(f3), 1);
    chk("br bubble_ex", 32'(b3), 1);
    chk("br no stall", 32'(s3_if), 0);
    tick();
    br = 0;
    chk("br entry1 cleared", 32'(pv3), 32'h2);
    chk("br fwd_rs1", 32'(r1_3), 0);
    drain();

    // add x0 ; add x15,x0,x0
    drive(1, 1, 1, 2, 1, 0, 1, 0);
    tick();
    drive(1, 0, 1, 0, 1, 15, 1, 0);
    tick();
    chk("x0 fwd_rs1", 32'(r1_3), 0);
    chk("x0 fwd_rs2", 32'(r2_3), 0);
    drain();

    // reset in the middle of a load-use stall
    drive(1, 1, 1, 0, 0, 7, 1, 1);
    tick();
    drive(1, 7, 1, 7, 1, 8, 1, 0);
    #1 chk("pre-reset stall", 32'(s3_if), 1);
    rst_n = 0;
    #1;
    chk("rst stall_if", 32'(s3_if), 0);
    chk("rst bubble_ex", 32'(b3), 0);
    chk("rst pipe_valid", 32'(pv3), 0);
    chk("rst pipe_valid n5", 32'(pv5), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    chk("post-rst pipe_valid", 32'(pv3), 0);

    // x3 producers in entries 1 and 3 of the 5-stage instance
    drive(1, 1, 1, 0, 0, 3, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 2, 1, 0, 0, 3, 1, 0);
    tick();
    chk("n5 pipe_valid", 32'(pv5), 32'h5);
    drive(1, 3, 1, 3, 0, 20, 1, 0);
    tick();
    chk("n5 youngest rs1", 32'(r1_5), 2);
    chk("n5 unused rs2", 32'(r2_5), 0);
    drain();

    // random traffic, checked by the compare process
    for (int j = 0; j < 100; j++) begin
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      br = ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/otter_hazard_ctrl.md
Name: otter_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the pipelined OTTER core.
- Keeps an internal scoreboard of in-flight instructions behind decode.
- Generates IF/DE stalls, DE/EX flush and bubble control, and registered forwarding selects for the instruction entering EX.
- Handles variable-latency data memory through a ready handshake. The fixed 3-stage, hardwired-pcWrite pipeline has none of this.

Parameters:
- NUM_STAGES, 3, scoreboard stages after decode (1=EX, 2=MEM, NUM_STAGES=WB); legal range 3..8.
- ADDR_W, 5, register address width.
- FWD_W, $clog2(NUM_STAGES+1), forwarding select width (derived; do not override).

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- de_valid  in  1  DE holds a real instruction.
- de_rs1_addr  in  ADDR_W  DE source register 1.
- de_rs2_addr  in  ADDR_W  DE source register 2.
- de_rs1_used  in  1  DE reads rs1.
- de_rs2_used  in  1  DE reads rs2.
- de_rd_addr  in  ADDR_W  DE destination register.
- de_reg_write  in  1  DE writes rd.
- de_mem_read  in  1  DE is a load.
- br_taken  in  1  taken branch/jump resolved by the instruction in EX.
- mem_ready  in  1  data memory response valid for the load in MEM.
- stall_if  out  1  hold PC.
- stall_de  out  1  hold IF/DE register.
- flush_de  out  1  squash IF/DE (insert NOP).
- bubble_ex  out  1  load NOP into DE/EX.
- fwd_rs1_sel  out  FWD_W  operand A source for the EX instruction: 0=regfile, k=stage k result.
- fwd_rs2_sel  out  FWD_W  operand B source, same encoding.
- pipe_valid  out  NUM_STAGES  bit k-1 = scoreboard stage k valid.

Behaviour:
- Reset (async on RESET_N low): all entries invalid, fwd selects 0, all outputs 0. Deassertion is synchronous to CLK via the external synchroniser.
- Entry fields: valid, rd, reg_write, is_load. A producer is an entry with valid & reg_write & rd!=0.
- mem_wait (comb) = entry2.valid & entry2.is_load & !mem_ready.
  - stall_if = stall_de = 1.
  - All entries and fwd selects hold.
  - br_taken and load-use are ignored this cycle; the CPU holds EX, so they are re-evaluated next cycle.
- flush (comb) = br_taken & entry1.valid & !mem_wait.
  - flush_de = 1, bubble_ex = 1, no stall.
  - Next cycle: entry1 invalid, fwd selects 0, other entries shift.
- load_use (comb) = de_valid & entry1 is a load producer & ((de_rs1_used & rs1==entry1.rd) | (de_rs2_used & rs2==entry1.rd)) & !mem_wait & !flush.
  - stall_if = stall_de = 1, bubble_ex = 1.
  - Entries 2..N shift; entry1 is invalid next cycle.
- Priority: mem_wait > flush > load_use > advance.
- Advance (none of the above): entry k+1 <= entry k; entry1 <= DE fields, qualified by de_valid.
- Forwarding, computed in DE and registered on advance:
  - Search entries 1..NUM_STAGES-1; the youngest (lowest k) matching producer wins; sel = k+1.
  - No match gives 0. Producers in WB need no forwarding: the regfile is write-before-read.
  - rs*_used = 0 forces sel 0.
  - After a load-use bubble the load sits in entry2, so the consumer gets sel 3.
- Single-cycle throughput; all stall/flush outputs are combinational from registered state plus inputs; no combinational path from mem_ready to fwd selects.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined: adds outputs perf_stall_cycles, perf_flushes and perf_mem_wait, each 32 bits.
  - These count, respectively, cycles with stall_if=1, flush events, and mem_wait cycles.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package otter_pipe_pkg holds:
  - opcode_t.
  - hazard_entry_t struct (valid, rd, reg_write, is_load).
  - FWD_REGFILE = 0.
  - Constants STG_EX = 1, STG_MEM = 2.
- One sub-module, otter_fwd_match: parametrised youngest-first comparator/priority encoder, instantiated once per source operand.

Test Plan:
- Back-to-back ALU, NUM_STAGES=3: `add x5` then `sub x6,x5,x1`, no stall -> fwd_rs1_sel=2, fwd_rs2_sel=0.
- Load-use: `lw x7` then `add x8,x7,x7` -> one cycle stall_if=stall_de=bubble_ex=1; next cycle fwd_rs1_sel=fwd_rs2_sel=3.
- Memory wait: load in MEM with mem_ready low for 4 cycles -> stall_if high 4 cycles, pipe_valid and fwd selects frozen; resumes the cycle after mem_ready=1.
- Branch: br_taken=1 with entry1 valid and a simultaneous load-use hazard in DE -> flush_de=1, no stall; next cycle entry1 invalid.
- rd=x0 producer followed by a reader of x0 -> fwd selects 0. RESET_N pulsed low mid-stall -> all outputs 0 immediately, pipe_valid=0.
- NUM_STAGES=5 with producers of x3 in entries 1 and 3 -> youngest wins, sel=2; with HAZARD_PERF_EN, perf counters match the stall/flush counts over a 100-cycle random run.
